// File: rtl/mult_controller.sv
// mult_controller: control FSM for a sequential shift-and-add multiplier datapath.
// Define MULT_CTRL_FASTSTART_EN to skip the ARMED start-release handshake.
module mult_controller #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a0,
    input  logic             start,
    output logic             lda,
    output logic             ldb,
    output logic             ldp,
    output logic             zero,
    output logic             shen,
    output logic             ready,
    output logic [2:0]       s,
    output logic [CNT_W-1:0] counter
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARMED = 3'd1;
    localparam logic [2:0] LDA   = 3'd2;
    localparam logic [2:0] LDB   = 3'd3;
    localparam logic [2:0] ADD   = 3'd4;
    localparam logic [2:0] SHIFT = 3'd5;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [2:0]       s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q   <= IDLE;
            cnt_q <= '0;
        end else begin
            s_q   <= s_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        s_d = IDLE;
        case (s_q)
`ifdef MULT_CTRL_FASTSTART_EN
            IDLE:  s_d = start ? LDA : IDLE;
`else
            IDLE:  s_d = start ? ARMED : IDLE;
`endif
            ARMED: s_d = start ? ARMED : LDA;
            LDA:   s_d = LDB;
            LDB:   s_d = ADD;
            ADD:   s_d = SHIFT;
            SHIFT: s_d = (cnt_q == LAST) ? IDLE : ADD;
            default: s_d = IDLE;
        endcase
        cnt_d = (s_q == LDB) ? '0 : (s_q == SHIFT) ? cnt_q + 1'b1 : cnt_q;
    end

    // ldp is the only Mealy output: a0 is consulted only while in ADD
    always_comb begin
        lda   = s_q == LDA;
        ldb   = s_q == LDB;
        zero  = s_q == LDB;
        ldp   = (s_q == ADD) && a0;
        shen  = s_q == SHIFT;
        ready = s_q == IDLE;
    end

    assign s       = s_q;
    assign counter = cnt_q;
endmodule

// File: tb/tb_mult_controller.sv
// tb_mult_controller: randomized operations checked against a per-cycle expected trace
// generated from the operation sequence (idle, handshake, load, WIDTH add/shift pairs).
module tb_mult_controller;
    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, a0, start;
    logic          lda, ldb, ldp, zero, shen, ready;
    logic [2:0]    s;
    logic [CW-1:0] counter;
    logic [31:0]   obs;
    int            checks = 0;
    int            errors = 0;
    int            last_cnt;

    always #5 clk = ~clk;

    mult_controller #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .a0(a0), .start(start),
        .lda(lda), .ldb(ldb), .ldp(ldp), .zero(zero), .shen(shen), .ready(ready),
        .s(s), .counter(counter)
    );

    assign obs = 32'({s, counter, lda, ldb, ldp, zero, shen, ready});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h (s,cnt,lda,ldb,ldp,zero,shen,ready)", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ev(input int st, input int cnt, input bit e_lda, input bit e_ldb,
                                       input bit e_ldp, input bit e_zero, input bit e_shen, input bit e_rdy);
        logic [2:0]    st3 = 3'(st);
        logic [CW-1:0] c   = CW'(cnt);
        return 32'({st3, c, e_lda, e_ldb, e_ldp, e_zero, e_shen, e_rdy});
    endfunction

    task automatic step(input bit st, input bit a);
        @(negedge clk);
        start = st;
        a0    = a;
        #1;
    endtask

    // mode: 0 random a0 per iteration, 1 all zeros, 2 all ones; abort_at: SHIFT iteration to reset in, -1 none
    task automatic run_op(input int hold, input bit busy, input int mode, input int abort_at);
        logic [W-1:0] av;
        av = (mode == 1) ? '0 : (mode == 2) ? '1 : W'($urandom);
        step(1'b1, 1'($urandom));
        chk("idle_start", obs, ev(0, last_cnt, 0, 0, 0, 0, 0, 1));
`ifndef MULT_CTRL_FASTSTART_EN
        for (int h = 1; h < hold; h++) begin
            step(1'b1, 1'($urandom));
            chk("armed_hold", obs, ev(1, last_cnt, 0, 0, 0, 0, 0, 0));
        end
        step(1'b0, 1'($urandom));
        chk("armed_rel", obs, ev(1, last_cnt, 0, 0, 0, 0, 0, 0));
`endif
        step(busy, 1'($urandom));
        chk("lda", obs, ev(2, last_cnt, 1, 0, 0, 0, 0, 0));
        step(busy, 1'($urandom));
        chk("ldb", obs, ev(3, last_cnt, 0, 1, 0, 1, 0, 0));
        for (int i = 0; i < W; i++) begin
            step(busy, av[i]);
            chk("add", obs, ev(4, i, 0, 0, av[i], 0, 0, 0));
            step(busy, 1'($urandom));
            chk("shift", obs, ev(5, i, 0, 0, 0, 0, 1, 0));
            if (i == abort_at) begin
                start = 1'b0;
                a0    = 1'b1;
                rst   = 1'b1;
                #1;
                chk("async_rst", obs, ev(0, 0, 0, 0, 0, 0, 0, 1));
                @(negedge clk);
                chk("rst_hold", obs, ev(0, 0, 0, 0, 0, 0, 0, 1));
                rst      = 1'b0;
                last_cnt = 0;
                return;
            end
        end
        last_cnt = W;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        a0       = 1'b0;
        last_cnt = 0;
        #12;
        chk("reset", obs, ev(0, 0, 0, 0, 0, 0, 0, 1));
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1);
        chk("idle_after_rst", obs, ev(0, 0, 0, 0, 0, 0, 0, 1));
        run_op(2, 1'b0, 1, -1);
        step(1'b0, 1'b1);
        chk("done_zeros", obs, ev(0, W, 0, 0, 0, 0, 0, 1));
        run_op(1, 1'b0, 2, -1);
        step(1'b0, 1'b0);
        chk("done_ones", obs, ev(0, W, 0, 0, 0, 0, 0, 1));
        run_op(3, 1'b1, 0, -1);
        run_op(1, 1'b0, 0, -1);
        run_op(2, 1'b0, 0, 3);
        step(1'b0, 1'b0);
        chk("idle_after_abort", obs, ev(0, 0, 0, 0, 0, 0, 0, 1));
        for (int n = 0; n < 30; n++) begin
            run_op(int'($urandom_range(1, 4)), 1'($urandom), 0,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1);
            if ($urandom_range(0, 1) == 1) begin
                step(1'b0, 1'($urandom));
                chk("idle_gap", obs, ev(0, last_cnt, 0, 0, 0, 0, 0, 1));
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
